block_mem_responder: RTL and testbench



---
 rtl/cache_pkg.sv | 34 +++
 rtl/block_mem_array.sv | 31 +++
 rtl/block_mem_responder.sv | 123 ++++++++++++
 tb/tb_block_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory interface types: block geometry and the request/response
// bus structs used between the data cache and the memory responder.
package cache_pkg;

    localparam int ADDR_WIDTH         = 32;
    localparam int BLOCK_SIZE_DEFAULT = 16;
    localparam int OFFSET_WIDTH       = $clog2(BLOCK_SIZE_DEFAULT);
    localparam int BLOCK_BITS         = BLOCK_SIZE_DEFAULT * 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
    } mem_r_req_bus_t;

    typedef struct packed {
        logic [BLOCK_BITS-1:0] rdata;
    } mem_r_resp_bus_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [BLOCK_BITS-1:0] data;
        logic                  wmask;
    } mem_w_req_bus_t;

    typedef struct packed {
        logic ok;
    } mem_w_resp_bus_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2
    } mem_state_t;

endpackage

// File: rtl/block_mem_array.sv
// Block-granular storage: combinational read, front-door write plus a backdoor
// write port that takes priority when both target the same block.
module block_mem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic [WIDTH-1:0] init_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Backdoor assignment comes last so it wins on a same-block collision.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_reg[wr_idx] <= wr_data;
        if (init_we)
            mem_reg[init_idx] <= init_data;
    end

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder for cache block refill / write-back: one request at a
// time, a single response pulse after a fixed latency, write priority.
module block_mem_responder
    import cache_pkg::*;
#(
    parameter int MEM_DEPTH_BLOCKS = 256,
    parameter int BLOCK_SIZE       = BLOCK_SIZE_DEFAULT,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  mem_r_req_bus_t          mem_r_req,
    input  logic                    mem_r_req_valid,
    output logic                    mem_r_req_ready,
    output mem_r_resp_bus_t         mem_r_resp,
    output logic                    mem_r_resp_valid,
    input  mem_w_req_bus_t          mem_w_req,
    input  logic                    mem_w_req_valid,
    output logic                    mem_w_req_ready,
    output mem_w_resp_bus_t         mem_w_resp,
    output logic                    mem_w_resp_valid,
    input  logic                    init_we,
    input  logic [ADDR_WIDTH-1:0]   init_addr,
    input  logic [BLOCK_SIZE*8-1:0] init_data,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);
    localparam int DW    = BLOCK_SIZE * 8;
    localparam int CNT_W = 16;

    mem_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DW-1:0]         data_reg, data_next;
    logic                  wmask_reg, wmask_next;
    logic [31:0]           rd_count_reg, wr_count_reg;
    logic [DW-1:0]         rd_data;
    logic                  cnt_zero;

    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            wmask_reg    <= 1'b0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            wmask_reg <= wmask_next;
            if (mem_r_resp_valid)
                rd_count_reg <= rd_count_reg + 32'd1;
            if (mem_w_resp_valid)
                wr_count_reg <= wr_count_reg + 32'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        wmask_next = wmask_reg;
        case (state_reg)
            IDLE: begin
                if (mem_w_req_valid) begin
                    state_next = WR_BUSY;
                    cnt_next   = CNT_W'(WRITE_LATENCY - 1);
                    addr_next  = mem_w_req.addr;
                    data_next  = mem_w_req.data;
                    wmask_next = mem_w_req.wmask;
                end else if (mem_r_req_valid) begin
                    state_next = RD_BUSY;
                    cnt_next   = CNT_W'(READ_LATENCY - 1);
                    addr_next  = mem_r_req.addr;
                end
            end
            RD_BUSY, WR_BUSY: begin
                if (cnt_zero)
                    state_next = IDLE;
                else
                    cnt_next = cnt_reg - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_w_req_ready  = (state_reg == IDLE);
    assign mem_r_req_ready  = (state_reg == IDLE) && !mem_w_req_valid;
    // Gated by rst so a transaction caught by reset neither responds nor commits.
    assign mem_r_resp_valid = !rst && (state_reg == RD_BUSY) && cnt_zero;
    assign mem_w_resp_valid = !rst && (state_reg == WR_BUSY) && cnt_zero;
    assign mem_r_resp.rdata = mem_r_resp_valid ? rd_data : '0;
    assign mem_w_resp.ok    = mem_w_resp_valid;
    assign rd_count         = rd_count_reg;
    assign wr_count         = wr_count_reg;

    block_mem_array #(
        .DEPTH (MEM_DEPTH_BLOCKS),
        .WIDTH (DW),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .rd_idx    (addr_reg[OFFSET_WIDTH +: IDX_W]),
        .rd_data   (rd_data),
        .wr_en     (mem_w_resp_valid && wmask_reg),
        .wr_idx    (addr_reg[OFFSET_WIDTH +: IDX_W]),
        .wr_data   (data_reg),
        .init_we   (init_we),
        .init_idx  (init_addr[OFFSET_WIDTH +: IDX_W]),
        .init_data (init_data)
    );

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: latency, write priority, masking,
// aliasing and reset abort, checked with immediate assertions.
module tb_block_mem_responder;
    import cache_pkg::*;

    localparam int RL = 4;
    localparam int WL = 2;

    logic            clk = 1'b0;
    logic            rst;
    mem_r_req_bus_t  r_req;
    logic            r_valid, r_ready;
    mem_r_resp_bus_t r_resp;
    logic            r_resp_valid;
    mem_w_req_bus_t  w_req;
    logic            w_valid, w_ready;
    mem_w_resp_bus_t w_resp;
    logic            w_resp_valid;
    logic            init_we;
    logic [31:0]     init_addr;
    logic [127:0]    init_data;
    logic [31:0]     rd_count, wr_count;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] BLK3 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] DA   = {16{8'hAA}};
    localparam logic [127:0] D60  = 128'h600D_F00D_1234_5678_9ABC_DEF0_0BAD_CAFE;
    localparam logic [127:0] D55  = {16{8'h55}};

    always #5 clk = ~clk;

    block_mem_responder #(
        .MEM_DEPTH_BLOCKS (256),
        .BLOCK_SIZE       (16),
        .READ_LATENCY     (RL),
        .WRITE_LATENCY    (WL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_r_req        (r_req),
        .mem_r_req_valid  (r_valid),
        .mem_r_req_ready  (r_ready),
        .mem_r_resp       (r_resp),
        .mem_r_resp_valid (r_resp_valid),
        .mem_w_req        (w_req),
        .mem_w_req_valid  (w_valid),
        .mem_w_req_ready  (w_ready),
        .mem_w_resp       (w_resp),
        .mem_w_resp_valid (w_resp_valid),
        .init_we          (init_we),
        .init_addr        (init_addr),
        .init_data        (init_data),
        .rd_count         (rd_count),
        .wr_count         (wr_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after ready rises again.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [127:0] exp, input int exp_cnt);
        r_req.addr = addr;
        r_valid    = 1'b1;
        #1 check({tag, "_rready_idle"}, 128'(r_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        r_valid    = 1'b0;
        r_req.addr = 32'hFFFF_FFF0;  // must be ignored while busy
        for (int k = 1; k <= RL; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("%s_rready_c%0d", tag, k), 128'(r_ready), 128'd0);
            check($sformatf("%s_rvalid_c%0d", tag, k), 128'(r_resp_valid), 128'(k == RL));
            check($sformatf("%s_rdata_c%0d", tag, k), r_resp.rdata, (k == RL) ? exp : 128'd0);
        end
        @(negedge clk);
        check({tag, "_rvalid_after"}, 128'(r_resp_valid), 128'd0);
        check({tag, "_rready_after"}, 128'(r_ready), 128'd1);
        check({tag, "_rd_count"}, 128'(rd_count), 128'(exp_cnt));
        $display("[TB] read  %s addr=%h rdata_exp=%h rd_count=%0d", tag, addr, exp, rd_count);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [127:0] data,
                            input logic wmask, input int exp_cnt);
        w_req.addr  = addr;
        w_req.data  = data;
        w_req.wmask = wmask;
        w_valid     = 1'b1;
        #1 check({tag, "_wready_idle"}, 128'(w_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        w_valid     = 1'b0;
        w_req.data  = '0;
        for (int k = 1; k <= WL; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("%s_wready_c%0d", tag, k), 128'(w_ready), 128'd0);
            check($sformatf("%s_rready_c%0d", tag, k), 128'(r_ready), 128'd0);
            check($sformatf("%s_wvalid_c%0d", tag, k), 128'(w_resp_valid), 128'(k == WL));
            check($sformatf("%s_ok_c%0d", tag, k), 128'(w_resp.ok), 128'(k == WL));
        end
        @(negedge clk);
        check({tag, "_wready_after"}, 128'(w_ready), 128'd1);
        check({tag, "_wr_count"}, 128'(wr_count), 128'(exp_cnt));
        $display("[TB] write %s addr=%h data=%h wmask=%0d wr_count=%0d", tag, addr, data, wmask, wr_count);
    endtask

    initial begin
        rst = 1'b1; r_valid = 1'b0; w_valid = 1'b0; init_we = 1'b0;
        r_req = '0; w_req = '0; init_addr = '0; init_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rready", 128'(r_ready), 128'd1);
        check("rst_wready", 128'(w_ready), 128'd1);
        check("rst_rvalid", 128'(r_resp_valid), 128'd0);
        check("rst_wvalid", 128'(w_resp_valid), 128'd0);
        check("rst_rdata", r_resp.rdata, 128'd0);
        check("rst_ok", 128'(w_resp.ok), 128'd0);
        check("rst_rd_count", 128'(rd_count), 128'd0);
        check("rst_wr_count", 128'(wr_count), 128'd0);
        $display("[TB] reset released");

        // Backdoor preload of block 3 and read back at full latency
        init_we = 1'b1; init_addr = 32'h30; init_data = BLK3;
        @(negedge clk);
        init_we = 1'b0;
        do_read("blk3", 32'h30, BLK3, 1);

        do_write("wr50", 32'h50, DA, 1'b1, 1);
        do_read("rd50", 32'h50, DA, 2);
        do_write("wr50_nomask", 32'h58, 128'h1234, 1'b0, 2);
        do_read("rd50_again", 32'h50, DA, 3);

        // Simultaneous valids: write wins, read waits for its turn
        w_req.addr = 32'h60; w_req.data = D60; w_req.wmask = 1'b1; w_valid = 1'b1;
        r_req.addr = 32'h60; r_valid = 1'b1;
        #1 check("both_rready", 128'(r_ready), 128'd0);
        check("both_wready", 128'(w_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        check("both_busy_rready", 128'(r_ready), 128'd0);
        check("both_busy_wvalid", 128'(w_resp_valid), 128'd0);
        @(negedge clk);
        check("both_wresp", 128'(w_resp_valid), 128'd1);
        check("both_rready_on_wresp", 128'(r_ready), 128'd0);
        r_valid = 1'b0;
        @(negedge clk);
        check("both_wr_count", 128'(wr_count), 128'd3);
        $display("[TB] write addr=00000060 (priority) wr_count=%0d", wr_count);
        do_read("rd60", 32'h60, D60, 4);

        do_write("wr1050", 32'h1050, D55, 1'b1, 4);
        do_read("alias50", 32'h0050, D55, 5);

        // Reset during a read: no response, counters cleared, storage kept
        r_req.addr = 32'h30; r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        check("abort_rvalid_c1", 128'(r_resp_valid), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_rvalid_rst%0d", k), 128'(r_resp_valid), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_rready", 128'(r_ready), 128'd1);
        check("abort_wready", 128'(w_ready), 128'd1);
        check("abort_rd_count", 128'(rd_count), 128'd0);
        check("abort_wr_count", 128'(wr_count), 128'd0);
        check("abort_rvalid_post", 128'(r_resp_valid), 128'd0);
        $display("[TB] reset during read rd_count=%0d", rd_count);
        do_read("post_rst_blk3", 32'h30, BLK3, 1);
        do_read("post_rst_alias", 32'h50, D55, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
